// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types for the N-phase traffic signal controller.
// FSM state encoding and lamp drive levels used by traffic_phase_ctrl.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2
   } tl_state_e;

   localparam logic LAMP_ON  = 1'b1;
   localparam logic LAMP_OFF = 1'b0;

endpackage

// File: rtl/rr_phase_picker.sv
// rr_phase_picker: combinational round-robin phase selector.
// Searches from last_phase+1 upward (mod NUM_PHASES) for the first demanding
// phase; last_phase itself is checked last. With no demand anywhere the
// result is last_phase+1 so the controller free-cycles.
module rr_phase_picker
   import traffic_pkg::*;
#(
   parameter int  NUM_PHASES = 4,
   localparam int PW         = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] demand,
   input  logic [PW-1:0]         last_phase,
   output logic [PW-1:0]         next_phase
);

   // Walk the candidates from farthest to nearest so the nearest demanding phase wins.
   always_comb begin
      logic [PW-1:0] idx_v;
      idx_v      = PW'((int'(last_phase) + 1) % NUM_PHASES);
      next_phase = idx_v;
      for (int i = NUM_PHASES; i >= 1; i--) begin
         idx_v      = PW'((int'(last_phase) + i) % NUM_PHASES);
         next_phase = demand[idx_v] ? idx_v : next_phase;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase demand-actuated traffic signal controller.
// Sequence per phase change: GREEN -> YELLOW -> ALLRED -> GREEN(next phase).
// Optional build macro: TRAFFIC_PREEMPT_EN adds emergency preemption
// (preempt_req / preempt_phase ports); undefined gives plain round-robin.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int  NUM_PHASES = 4,
   parameter int  MIN_GREEN  = 8,
   parameter int  MAX_GREEN  = 20,
   parameter int  YELLOW_CYC = 3,
   parameter int  ALLRED_CYC = 2,
   localparam int PW         = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_PHASES-1:0] demand,
`ifdef TRAFFIC_PREEMPT_EN
   input  logic                  preempt_req,
   input  logic [PW-1:0]         preempt_phase,
`endif
   output logic [NUM_PHASES-1:0] red,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] green,
   output logic [PW-1:0]         active_phase,
   output logic [1:0]            state_o
);

   localparam int TW = $clog2(MAX_GREEN + 1);

   tl_state_e             state_r;
   logic [PW-1:0]         phase_r;
   logic [TW-1:0]         timer_r;
   logic [NUM_PHASES-1:0] red_r;
   logic [NUM_PHASES-1:0] yellow_r;
   logic [NUM_PHASES-1:0] green_r;

   logic [PW-1:0]         pick_s;
   logic [PW-1:0]         next_phase_s;
   logic [NUM_PHASES-1:0] phase_mask_s;
   logic [TW-1:0]         timer_inc_s;
   logic                  own_demand_s;
   logic                  other_demand_s;
   logic                  min_done_s;
   logic                  max_done_s;
   logic                  allred_done_s;
   logic                  yellow_done_s;
   logic                  normal_exit_s;
   logic                  go_yellow_s;

   // One-hot lamp vector selecting a single phase.
   function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PW-1:0] ph);
      return {{(NUM_PHASES-1){LAMP_OFF}}, LAMP_ON} << ph;
   endfunction

   rr_phase_picker #(
      .NUM_PHASES (NUM_PHASES)
   ) u_picker (
      .demand     (demand),
      .last_phase (phase_r),
      .next_phase (pick_s)
   );

   // Demand split into the served phase and every other phase; timer thresholds.
   always_comb begin
      phase_mask_s   = phase_onehot(phase_r);
      own_demand_s   = |(demand & phase_mask_s);
      other_demand_s = |(demand & ~phase_mask_s);
      min_done_s     = (int'(timer_r) >= MIN_GREEN - 1);
      max_done_s     = (int'(timer_r) >= MAX_GREEN - 1);
      allred_done_s  = (int'(timer_r) >= ALLRED_CYC - 1);
      yellow_done_s  = (int'(timer_r) >= YELLOW_CYC - 1);
      timer_inc_s    = (int'(timer_r) < MAX_GREEN) ? (timer_r + TW'(1'b1)) : timer_r;
   end

   // Actuated green end: once MIN_GREEN is served, a competing call gaps the
   // green out if the served phase has no call of its own; a served phase that
   // keeps calling is extended until MAX_GREEN. Without competing calls green rests.
   always_comb begin
      normal_exit_s = 1'b0;
      if (min_done_s && other_demand_s) begin
         if (!own_demand_s || max_done_s) begin
            normal_exit_s = 1'b1;
         end else begin
            normal_exit_s = 1'b0;
         end
      end else begin
         normal_exit_s = 1'b0;
      end
   end

`ifdef TRAFFIC_PREEMPT_EN
   logic preempt_valid_s;

   // Preempt toward a nonexistent phase is ignored.
   always_comb begin
      preempt_valid_s = preempt_req && (int'(preempt_phase) < NUM_PHASES);
   end

   // Preemption overrides both the green exit decision and the next-phase choice.
   always_comb begin
      go_yellow_s  = normal_exit_s;
      next_phase_s = pick_s;
      if (preempt_valid_s) begin
         go_yellow_s  = (preempt_phase != phase_r);
         next_phase_s = preempt_phase;
      end else begin
         go_yellow_s  = normal_exit_s;
         next_phase_s = pick_s;
      end
   end
`else
   // Without preemption the green exit and next phase come straight from the normal rules.
   always_comb begin
      go_yellow_s  = normal_exit_s;
      next_phase_s = pick_s;
   end
`endif

   // Phase FSM with timer and registered lamp drives.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_ALLRED;
         phase_r  <= PW'(NUM_PHASES - 1);
         timer_r  <= {TW{1'b0}};
         red_r    <= {NUM_PHASES{LAMP_ON}};
         yellow_r <= {NUM_PHASES{LAMP_OFF}};
         green_r  <= {NUM_PHASES{LAMP_OFF}};
      end else begin
         case (state_r)
            ST_ALLRED: begin
               if (allred_done_s) begin
                  state_r  <= ST_GREEN;
                  phase_r  <= next_phase_s;
                  timer_r  <= {TW{1'b0}};
                  green_r  <= phase_onehot(next_phase_s);
                  red_r    <= ~phase_onehot(next_phase_s);
                  yellow_r <= {NUM_PHASES{LAMP_OFF}};
               end else begin
                  timer_r <= timer_inc_s;
               end
            end
            ST_GREEN: begin
               if (go_yellow_s) begin
                  state_r  <= ST_YELLOW;
                  timer_r  <= {TW{1'b0}};
                  yellow_r <= phase_mask_s;
                  green_r  <= {NUM_PHASES{LAMP_OFF}};
               end else begin
                  timer_r <= timer_inc_s;
               end
            end
            ST_YELLOW: begin
               if (yellow_done_s) begin
                  state_r  <= ST_ALLRED;
                  timer_r  <= {TW{1'b0}};
                  red_r    <= {NUM_PHASES{LAMP_ON}};
                  yellow_r <= {NUM_PHASES{LAMP_OFF}};
                  green_r  <= {NUM_PHASES{LAMP_OFF}};
               end else begin
                  timer_r <= timer_inc_s;
               end
            end
            default: begin
               state_r  <= ST_ALLRED;
               timer_r  <= {TW{1'b0}};
               red_r    <= {NUM_PHASES{LAMP_ON}};
               yellow_r <= {NUM_PHASES{LAMP_OFF}};
               green_r  <= {NUM_PHASES{LAMP_OFF}};
            end
         endcase
      end
   end

   assign red          = red_r;
   assign yellow       = yellow_r;
   assign green        = green_r;
   assign active_phase = phase_r;
   assign state_o      = state_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for traffic_phase_ctrl (defaults).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;
   import traffic_pkg::*;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] demand = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
   logic       preempt_req   = 1'b0;
   logic [1:0] preempt_phase = 2'd0;
`endif
   logic [3:0] red;
   logic [3:0] yellow;
   logic [3:0] green;
   logic [1:0] active_phase;
   logic [1:0] state_o;

   localparam logic [1:0] S_AR = 2'd0;
   localparam logic [1:0] S_GR = 2'd1;
   localparam logic [1:0] S_YE = 2'd2;

   typedef struct {
      int         cyc;
      int         id;
      logic [1:0] st;
      logic [1:0] ph;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   next_id = 1;

   traffic_phase_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .demand        (demand),
`ifdef TRAFFIC_PREEMPT_EN
      .preempt_req   (preempt_req),
      .preempt_phase (preempt_phase),
`endif
      .red           (red),
      .yellow        (yellow),
      .green         (green),
      .active_phase  (active_phase),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected {red,yellow,green} for a state and served phase.
   function automatic logic [11:0] lamps(input logic [1:0] st, input logic [1:0] ph);
      logic [3:0] one;
      one = 4'b0001 << ph;
      case (st)
         2'd0:    return {4'b1111, 4'b0000, 4'b0000};
         2'd1:    return {~one, 4'b0000, one};
         2'd2:    return {~one, one, 4'b0000};
         default: return {4'b0000, 4'b0000, 4'b0000};
      endcase
   endfunction

   task automatic expect_at(input int c, input logic [1:0] st, input logic [1:0] ph);
      exp_t e;
      e.cyc = c;
      e.id  = next_id;
      e.st  = st;
      e.ph  = ph;
      next_id = next_id + 1;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step(1);
   endtask

   // Monitor: pop every expectation due at this cycle and compare.
   initial begin
      exp_t       e;
      logic [11:0] want;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e    = sb_q.pop_front();
            want = lamps(e.st, e.ph);
            total = total + 1;
            if (e.cyc != cyc || state_o !== e.st || active_phase !== e.ph ||
                {red, yellow, green} !== want) begin
               bad = bad + 1;
               $display("FAIL chk%0d at cyc %0d (due %0d): got st=%0d ph=%0d r=%b y=%b g=%b, want st=%0d ph=%0d r=%b y=%b g=%b",
                        e.id, cyc, e.cyc, state_o, active_phase, red, yellow, green,
                        e.st, e.ph, want[11:8], want[7:4], want[3:0]);
            end
         end
      end
   end

   initial begin
      int b;
      int s;
      int g;
`ifdef TRAFFIC_PREEMPT_EN
      int h;
      int q;
`endif
      // Reset for 3 cycles, no demand: ALLRED 2 cycles then free-cycle to phase 0.
      reset  = 1'b1;
      demand = 4'b0000;
      step(3);
      reset = 1'b0;
      b = cyc;
      expect_at(b,     S_AR, 2'd3);
      expect_at(b + 1, S_AR, 2'd3);
      expect_at(b + 2, S_GR, 2'd0);
      step_to(b + 2);

      // Only phase 0 calls: green rests well beyond MAX_GREEN.
      demand = 4'b0001;
      expect_at(b + 12, S_GR, 2'd0);
      expect_at(b + 30, S_GR, 2'd0);
      expect_at(b + 47, S_GR, 2'd0);
      step_to(b + 47);

      // All phases call: 0,1,2,3,0 each exactly MAX_GREEN green.
      demand = 4'b1111;
      reset  = 1'b1;
      step(2);
      reset = 1'b0;
      b = cyc;
      expect_at(b, S_AR, 2'd3);
      for (int k = 0; k < 5; k++) begin
         s = b + 2 + 25 * k;
         expect_at(s,      S_GR, 2'(k % 4));
         expect_at(s + 19, S_GR, 2'(k % 4));
         expect_at(s + 20, S_YE, 2'(k % 4));
         if (k < 4) begin
            expect_at(s + 23, S_AR, 2'(k % 4));
         end
      end
      step_to(b + 2 + 25 * 4 + 20);

      // Reset during yellow: next cycle is the reset state, timer restarts.
      reset  = 1'b1;
      demand = 4'b0000;
      step(1);
      reset = 1'b0;
      b = cyc;
      expect_at(b,     S_AR, 2'd3);
      expect_at(b + 1, S_AR, 2'd3);
      expect_at(b + 2, S_GR, 2'd0);
      g = b + 2;

      // Phase 0 green, phase 2 calls in green cycle 2: MIN_GREEN, yellow, all-red, phase 2.
      step_to(g + 1);
      demand = 4'b0100;
      expect_at(g + 7,  S_GR, 2'd0);
      expect_at(g + 8,  S_YE, 2'd0);
      expect_at(g + 10, S_YE, 2'd0);
      expect_at(g + 11, S_AR, 2'd0);
      expect_at(g + 12, S_AR, 2'd0);
      expect_at(g + 13, S_GR, 2'd2);
      step_to(g + 14);

`ifdef TRAFFIC_PREEMPT_EN
      // Preempt to phase 3 while phase 1 is in green cycle 3; hold, then release.
      demand = 4'b0010;
      reset  = 1'b1;
      step(1);
      reset = 1'b0;
      b = cyc;
      h = b + 2;
      expect_at(b, S_AR, 2'd3);
      expect_at(h, S_GR, 2'd1);
      step_to(h + 2);
      preempt_req   = 1'b1;
      preempt_phase = 2'd3;
      expect_at(h + 3,  S_YE, 2'd1);
      expect_at(h + 5,  S_YE, 2'd1);
      expect_at(h + 6,  S_AR, 2'd1);
      expect_at(h + 7,  S_AR, 2'd1);
      expect_at(h + 8,  S_GR, 2'd3);
      expect_at(h + 33, S_GR, 2'd3);
      q = h + 37;
      expect_at(q, S_GR, 2'd3);
      step_to(q);
      preempt_req = 1'b0;
      expect_at(q + 1, S_YE, 2'd3);
      expect_at(q + 4, S_AR, 2'd3);
      expect_at(q + 6, S_GR, 2'd1);
      step_to(q + 7);
`endif

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 200 && sb_q.size() > 0; w++) step(1);
      step(2);
      if (sb_q.size() > 0) begin
         $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
         bad = bad + sb_q.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
